// File: rtl/ps2_rx_decoder.sv
// PS/2 device-to-host receiver: synchronises the raw lines, deserialises 11-bit frames and folds E0/F0 prefixes into flags.
// Optional ps2_clk level filter is enabled by defining PS2_GLITCH_FILTER_EN.
module ps2_rx_decoder #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       is_break,
    output logic       is_ext,
    output logic       err_parity,
    output logic       err_frame
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    if (FILTER_LEN < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("ps2_rx_decoder: FILTER_LEN must be >= 1 and TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    logic clk_s1, clk_s2, dat_s1, dat_s2;
    logic clk_lvl, clk_prev, fall;

    // Both lines get identical sync depth so data stays aligned with the clock edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_dat;
            dat_s2 <= dat_s1;
        end
    end

`ifdef PS2_GLITCH_FILTER_EN
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic          clk_filt;
    logic [FW-1:0] filt_cnt;

    // Level only follows the input after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s2 == clk_filt) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            clk_filt <= clk_s2;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    assign clk_lvl = clk_filt;
`else
    assign clk_lvl = clk_s2;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) clk_prev <= 1'b1;
        else         clk_prev <= clk_lvl;
    end

    assign fall = clk_prev & ~clk_lvl;

    state_t          state;
    logic [7:0]      shreg;
    logic [2:0]      bit_cnt;
    logic            par;
    logic [TO_W-1:0] to_cnt;
    logic            ext_pend, brk_pend;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            par        <= 1'b0;
            to_cnt     <= '0;
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
            code       <= '0;
            code_valid <= 1'b0;
            is_break   <= 1'b0;
            is_ext     <= 1'b0;
            err_parity <= 1'b0;
            err_frame  <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            err_parity <= 1'b0;
            err_frame  <= 1'b0;
            case (state)
                IDLE: begin
                    to_cnt <= '0;
                    if (fall) begin
                        if (!dat_s2) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            err_frame <= 1'b1;
                            ext_pend  <= 1'b0;
                            brk_pend  <= 1'b0;
                        end
                    end
                end
                default: begin
                    if (fall) begin
                        to_cnt <= '0;
                        case (state)
                            DATA: begin
                                shreg[bit_cnt] <= dat_s2;
                                if (bit_cnt == 3'd7) state <= PARITY;
                                else                 bit_cnt <= bit_cnt + 3'd1;
                            end
                            PARITY: begin
                                par   <= dat_s2;
                                state <= STOP;
                            end
                            default: begin
                                state <= IDLE;
                                // Parity is judged before the stop bit so only one error is reported.
                                if (!(^{shreg, par})) begin
                                    err_parity <= 1'b1;
                                    ext_pend   <= 1'b0;
                                    brk_pend   <= 1'b0;
                                end else if (!dat_s2) begin
                                    err_frame <= 1'b1;
                                    ext_pend  <= 1'b0;
                                    brk_pend  <= 1'b0;
                                end else if (shreg == 8'hE0) begin
                                    ext_pend <= 1'b1;
                                end else if (shreg == 8'hF0) begin
                                    brk_pend <= 1'b1;
                                end else begin
                                    code       <= shreg;
                                    is_break   <= brk_pend;
                                    is_ext     <= ext_pend;
                                    code_valid <= 1'b1;
                                    ext_pend   <= 1'b0;
                                    brk_pend   <= 1'b0;
                                end
                            end
                        endcase
                    end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state     <= IDLE;
                        to_cnt    <= '0;
                        err_frame <= 1'b1;
                        ext_pend  <= 1'b0;
                        brk_pend  <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
